// File: rtl/logo_motion_if.sv
// Scan-position in / logo-position out bundle for logo_motion.
// The scan generator side uses the master modport; logo_motion uses slave.
interface logo_motion_if;
    logic       en;
    logic [9:0] x_px;
    logic [9:0] y_px;
    logic [9:0] x_logo;
    logic [9:0] y_logo;
    logic       dir_x;
    logic       dir_y;
    logic       bounce;

    modport master (
        output en,
        output x_px,
        output y_px,
        input  x_logo,
        input  y_logo,
        input  dir_x,
        input  dir_y,
        input  bounce
    );

    modport slave (
        input  en,
        input  x_px,
        input  y_px,
        output x_logo,
        output y_logo,
        output dir_x,
        output dir_y,
        output bounce
    );
endinterface

// File: rtl/logo_motion.sv
// Bouncing-logo position generator.
// Watches the scan position for the last visible pixel. Once every FRAME_DIV frames
// it moves the logo's top-left corner by (STEP_X, STEP_Y), reflecting off the screen
// edges. Moves happen only after the visible frame ends, so scan-out sees a stable
// position.
module logo_motion #(
    parameter int unsigned SCREEN_W  = 640,
    parameter int unsigned SCREEN_H  = 480,
    parameter int unsigned LOGO_W    = 80,
    parameter int unsigned LOGO_H    = 96,
    parameter int unsigned STEP_X    = 1,
    parameter int unsigned STEP_Y    = 1,
    parameter int unsigned X_INIT    = 0,
    parameter int unsigned Y_INIT    = 0,
    parameter int unsigned FRAME_DIV = 1
) (
    input logic          clk,
    input logic          clr,
    logo_motion_if.slave bus
);

    // Positions are compared in 11 bits so x + STEP never wraps.
    localparam logic [10:0] MAX_X    = 11'(SCREEN_W - LOGO_W);
    localparam logic [10:0] MAX_Y    = 11'(SCREEN_H - LOGO_H);
    localparam logic [10:0] STEP_XW  = 11'(STEP_X);
    localparam logic [10:0] STEP_YW  = 11'(STEP_Y);
    localparam logic [9:0]  LAST_X   = 10'(SCREEN_W - 1);
    localparam logic [9:0]  LAST_Y   = 10'(SCREEN_H - 1);
    localparam logic [9:0]  X_RST    = 10'(X_INIT);
    localparam logic [9:0]  Y_RST    = 10'(Y_INIT);
    localparam logic [7:0]  CNT_LAST = 8'(FRAME_DIV - 1);

    typedef enum logic [0:0] {
        StWait,
        StUpdate
    } state_e;

    state_e      state_q, state_d;
    logic        eof, eof_q, tick;
    logic [7:0]  frame_cnt_q, frame_cnt_d;
    logic [9:0]  x_q, x_d;
    logic [9:0]  y_q, y_d;
    logic        dir_x_q, dir_x_d;
    logic        dir_y_q, dir_y_d;
    logic        bounce_q, bounce_d;
    logic        hit_x, hit_y;
    logic [10:0] x_sum, y_sum;

    // Last visible pixel; the edge detect makes a held pixel count as one frame.
    assign eof  = (bus.x_px == LAST_X) && (bus.y_px == LAST_Y);
    assign tick = eof & ~eof_q;

    // Frame divider and WAIT/UPDATE sequencing.
    always_comb begin
        state_d     = state_q;
        frame_cnt_d = frame_cnt_q;
        unique case (state_q)
            StWait: begin
                if (tick && bus.en) begin
                    if (frame_cnt_q == CNT_LAST) begin
                        frame_cnt_d = '0;
                        state_d     = StUpdate;
                    end else begin
                        frame_cnt_d = frame_cnt_q + 8'd1;
                    end
                end
            end
            StUpdate: begin
                state_d = StWait;
            end
        endcase
    end

    // Horizontal step with reflection at 0 and MAX_X.
    always_comb begin
        x_d     = x_q;
        dir_x_d = dir_x_q;
        hit_x   = 1'b0;
        x_sum   = {1'b0, x_q} + STEP_XW;
        if (state_q == StUpdate) begin
            if (dir_x_q) begin
                if (x_sum >= MAX_X) begin
                    x_d     = MAX_X[9:0];
                    dir_x_d = 1'b0;
                    hit_x   = 1'b1;
                end else begin
                    x_d = x_sum[9:0];
                end
            end else begin
                if ({1'b0, x_q} <= STEP_XW) begin
                    x_d     = '0;
                    dir_x_d = 1'b1;
                    hit_x   = 1'b1;
                end else begin
                    x_d = x_q - STEP_XW[9:0];
                end
            end
        end
    end

    // Vertical step with reflection at 0 and MAX_Y.
    always_comb begin
        y_d     = y_q;
        dir_y_d = dir_y_q;
        hit_y   = 1'b0;
        y_sum   = {1'b0, y_q} + STEP_YW;
        if (state_q == StUpdate) begin
            if (dir_y_q) begin
                if (y_sum >= MAX_Y) begin
                    y_d     = MAX_Y[9:0];
                    dir_y_d = 1'b0;
                    hit_y   = 1'b1;
                end else begin
                    y_d = y_sum[9:0];
                end
            end else begin
                if ({1'b0, y_q} <= STEP_YW) begin
                    y_d     = '0;
                    dir_y_d = 1'b1;
                    hit_y   = 1'b1;
                end else begin
                    y_d = y_q - STEP_YW[9:0];
                end
            end
        end
    end

    // A corner hit sets both flags but still yields a single pulse.
    always_comb begin
        bounce_d = hit_x | hit_y;
    end

    // State registers; clr wins over everything, including an in-flight update.
    always_ff @(posedge clk) begin
        if (!clr) begin
            state_q     <= StWait;
            eof_q       <= 1'b0;
            frame_cnt_q <= '0;
            x_q         <= X_RST;
            y_q         <= Y_RST;
            dir_x_q     <= 1'b1;
            dir_y_q     <= 1'b1;
            bounce_q    <= 1'b0;
        end else begin
            state_q     <= state_d;
            eof_q       <= eof;
            frame_cnt_q <= frame_cnt_d;
            x_q         <= x_d;
            y_q         <= y_d;
            dir_x_q     <= dir_x_d;
            dir_y_q     <= dir_y_d;
            bounce_q    <= bounce_d;
        end
    end

    // Position must stay inside the reachable window.
    always_ff @(posedge clk) begin
        if (clr) begin
            assert ({1'b0, x_q} <= MAX_X);
            assert ({1'b0, y_q} <= MAX_Y);
        end
    end

    assign bus.x_logo = x_q;
    assign bus.y_logo = y_q;
    assign bus.dir_x  = dir_x_q;
    assign bus.dir_y  = dir_y_q;
    assign bus.bounce = bounce_q;

endmodule

// File: tb/tb_logo_motion.sv
// Bench for logo_motion: five differently parameterised instances share one scan
// stream and are compared frame by frame against a per-frame behavioural model.
module tb_logo_motion;

    localparam int N     = 5;
    localparam int MAX_X = 560;
    localparam int MAX_Y = 384;
    localparam int P_XI  [N] = '{0, 557, 560, 0, 100};
    localparam int P_YI  [N] = '{0, 0, 384, 0, 200};
    localparam int P_SX  [N] = '{1, 2, 1, 1, 50};
    localparam int P_SY  [N] = '{1, 1, 1, 1, 40};
    localparam int P_DIV [N] = '{1, 1, 1, 3, 2};

    logic       clk = 1'b0;
    logic       clr = 1'b0;
    logic       en = 1'b0;
    logic [9:0] x_px = 10'd0;
    logic [9:0] y_px = 10'd0;

    always #5 clk = ~clk;

    logo_motion_if ifc0 ();
    logo_motion_if ifc1 ();
    logo_motion_if ifc2 ();
    logo_motion_if ifc3 ();
    logo_motion_if ifc4 ();

    assign ifc0.en = en; assign ifc0.x_px = x_px; assign ifc0.y_px = y_px;
    assign ifc1.en = en; assign ifc1.x_px = x_px; assign ifc1.y_px = y_px;
    assign ifc2.en = en; assign ifc2.x_px = x_px; assign ifc2.y_px = y_px;
    assign ifc3.en = en; assign ifc3.x_px = x_px; assign ifc3.y_px = y_px;
    assign ifc4.en = en; assign ifc4.x_px = x_px; assign ifc4.y_px = y_px;

    logo_motion u0 (.clk(clk), .clr(clr), .bus(ifc0));
    logo_motion #(.X_INIT(557), .STEP_X(2)) u1 (.clk(clk), .clr(clr), .bus(ifc1));
    logo_motion #(.X_INIT(560), .Y_INIT(384)) u2 (.clk(clk), .clr(clr), .bus(ifc2));
    logo_motion #(.FRAME_DIV(3)) u3 (.clk(clk), .clr(clr), .bus(ifc3));
    logo_motion #(.X_INIT(100), .Y_INIT(200), .STEP_X(50), .STEP_Y(40), .FRAME_DIV(2)) u4 (
        .clk(clk), .clr(clr), .bus(ifc4));

    logic [9:0] ox [N];
    logic [9:0] oy [N];
    logic       odx [N];
    logic       ody [N];
    logic       ob [N];

    assign ox[0] = ifc0.x_logo; assign oy[0] = ifc0.y_logo;
    assign odx[0] = ifc0.dir_x; assign ody[0] = ifc0.dir_y; assign ob[0] = ifc0.bounce;
    assign ox[1] = ifc1.x_logo; assign oy[1] = ifc1.y_logo;
    assign odx[1] = ifc1.dir_x; assign ody[1] = ifc1.dir_y; assign ob[1] = ifc1.bounce;
    assign ox[2] = ifc2.x_logo; assign oy[2] = ifc2.y_logo;
    assign odx[2] = ifc2.dir_x; assign ody[2] = ifc2.dir_y; assign ob[2] = ifc2.bounce;
    assign ox[3] = ifc3.x_logo; assign oy[3] = ifc3.y_logo;
    assign odx[3] = ifc3.dir_x; assign ody[3] = ifc3.dir_y; assign ob[3] = ifc3.bounce;
    assign ox[4] = ifc4.x_logo; assign oy[4] = ifc4.y_logo;
    assign odx[4] = ifc4.dir_x; assign ody[4] = ifc4.dir_y; assign ob[4] = ifc4.bounce;

    // Model state, advanced once per frame.
    int mx [N];
    int my [N];
    int mcnt [N];
    bit mdx [N];
    bit mdy [N];
    bit mhit [N];

    int n_checks = 0;
    int n_pass   = 0;

    task automatic model_reset();
        for (int i = 0; i < N; i++) begin
            mx[i] = P_XI[i]; my[i] = P_YI[i];
            mdx[i] = 1'b1;   mdy[i] = 1'b1;
            mcnt[i] = 0;     mhit[i] = 1'b0;
        end
    endtask

    // One frame: move by a signed step, clamp into the window, reverse on contact.
    task automatic model_frame();
        int nx, ny;
        for (int i = 0; i < N; i++) begin
            mhit[i] = 1'b0;
            if (en) begin
                mcnt[i] = (mcnt[i] + 1) % P_DIV[i];
                if (mcnt[i] == 0) begin
                    nx = mdx[i] ? mx[i] + P_SX[i] : mx[i] - P_SX[i];
                    ny = mdy[i] ? my[i] + P_SY[i] : my[i] - P_SY[i];
                    if (nx >= MAX_X) begin nx = MAX_X; mdx[i] = 1'b0; mhit[i] = 1'b1; end
                    else if (nx <= 0) begin nx = 0; mdx[i] = 1'b1; mhit[i] = 1'b1; end
                    if (ny >= MAX_Y) begin ny = MAX_Y; mdy[i] = 1'b0; mhit[i] = 1'b1; end
                    else if (ny <= 0) begin ny = 0; mdy[i] = 1'b1; mhit[i] = 1'b1; end
                    mx[i] = nx; my[i] = ny;
                end
            end
        end
    endtask

    task automatic set_off();
        int x, y;
        do begin
            x = $urandom_range(0, 1023);
            y = $urandom_range(0, 1023);
        end while (x == 639 && y == 479);
        x_px = 10'(x);
        y_px = 10'(y);
    endtask

    // Called at posedge+1 with the scan off the last pixel for at least one edge.
    // Holds the last pixel for `hold` (>=3) edges and checks timing of the move.
    task automatic run_frame(input int hold, input int gap);
        int px [N];
        int py [N];
        bit pdx [N];
        bit pdy [N];
        for (int i = 0; i < N; i++) begin
            px[i] = mx[i]; py[i] = my[i]; pdx[i] = mdx[i]; pdy[i] = mdy[i];
        end
        model_frame();
        x_px = 10'd639;
        y_px = 10'd479;
        @(posedge clk); #1;
        for (int i = 0; i < N; i++) begin
            n_checks++;
            if ({ox[i], oy[i], odx[i], ody[i], ob[i]} !==
                {10'(px[i]), 10'(py[i]), pdx[i], pdy[i], 1'b0})
                $display("FAIL pre_update u%0d: got x=%0d y=%0d dx=%0b dy=%0b b=%0b want x=%0d y=%0d dx=%0b dy=%0b b=0",
                         i, ox[i], oy[i], odx[i], ody[i], ob[i], px[i], py[i], pdx[i], pdy[i]);
            else n_pass++;
        end
        @(posedge clk); #1;
        for (int i = 0; i < N; i++) begin
            n_checks++;
            if ({ox[i], oy[i], odx[i], ody[i], ob[i]} !==
                {10'(mx[i]), 10'(my[i]), mdx[i], mdy[i], mhit[i]})
                $display("FAIL update u%0d: got x=%0d y=%0d dx=%0b dy=%0b b=%0b want x=%0d y=%0d dx=%0b dy=%0b b=%0b",
                         i, ox[i], oy[i], odx[i], ody[i], ob[i], mx[i], my[i], mdx[i], mdy[i], mhit[i]);
            else n_pass++;
        end
        for (int k = 2; k < hold; k++) begin
            @(posedge clk); #1;
            for (int i = 0; i < N; i++) begin
                n_checks++;
                if ({ox[i], oy[i], odx[i], ody[i], ob[i]} !==
                    {10'(mx[i]), 10'(my[i]), mdx[i], mdy[i], 1'b0})
                    $display("FAIL held u%0d cyc%0d: got x=%0d y=%0d dx=%0b dy=%0b b=%0b want x=%0d y=%0d dx=%0b dy=%0b b=0",
                             i, k, ox[i], oy[i], odx[i], ody[i], ob[i], mx[i], my[i], mdx[i], mdy[i]);
                else n_pass++;
            end
        end
        set_off();
        repeat (gap) begin
            @(posedge clk); #1;
        end
    endtask

    task automatic test_reset();
        clr = 1'b0;
        en  = 1'b1;
        x_px = 10'd639;
        y_px = 10'd479;
        repeat (3) begin
            @(posedge clk); #1;
        end
        model_reset();
        for (int i = 0; i < N; i++) begin
            n_checks++;
            if ({ox[i], oy[i], odx[i], ody[i], ob[i]} !==
                {10'(P_XI[i]), 10'(P_YI[i]), 1'b1, 1'b1, 1'b0})
                $display("FAIL reset u%0d: got x=%0d y=%0d dx=%0b dy=%0b b=%0b want x=%0d y=%0d dx=1 dy=1 b=0",
                         i, ox[i], oy[i], odx[i], ody[i], ob[i], P_XI[i], P_YI[i]);
            else n_pass++;
        end
        set_off();
        @(posedge clk); #1;
        clr = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic test_idle();
        en = 1'b0;
        repeat (10) run_frame($urandom_range(3, 6), $urandom_range(1, 3));
        for (int i = 0; i < N; i++) begin
            n_checks++;
            if ({ox[i], oy[i], odx[i], ody[i]} !== {10'(P_XI[i]), 10'(P_YI[i]), 1'b1, 1'b1})
                $display("FAIL idle u%0d: got x=%0d y=%0d dx=%0b dy=%0b want x=%0d y=%0d dx=1 dy=1",
                         i, ox[i], oy[i], odx[i], ody[i], P_XI[i], P_YI[i]);
            else n_pass++;
        end
    endtask

    task automatic test_three_frames();
        en = 1'b1;
        repeat (3) run_frame(3, 2);
        n_checks++;
        if (ox[0] !== 10'd3 || oy[0] !== 10'd3)
            $display("FAIL default_3f: got (%0d,%0d) want (3,3)", ox[0], oy[0]);
        else n_pass++;
        n_checks++;
        if (ox[1] !== 10'd558 || odx[1] !== 1'b0)
            $display("FAIL edge_right: got x=%0d dx=%0b want x=558 dx=0", ox[1], odx[1]);
        else n_pass++;
        n_checks++;
        if (ox[2] !== 10'd558 || oy[2] !== 10'd382 || odx[2] !== 1'b0 || ody[2] !== 1'b0)
            $display("FAIL corner: got (%0d,%0d) dx=%0b dy=%0b want (558,382) dx=0 dy=0",
                     ox[2], oy[2], odx[2], ody[2]);
        else n_pass++;
        n_checks++;
        if (ox[3] !== 10'd1)
            $display("FAIL div3_3f: got x=%0d want 1", ox[3]);
        else n_pass++;
    endtask

    task automatic test_hold();
        run_frame(50, 2);
        n_checks++;
        if (ox[0] !== 10'd4 || oy[0] !== 10'd4)
            $display("FAIL hold50: got (%0d,%0d) want (4,4)", ox[0], oy[0]);
        else n_pass++;
    endtask

    task automatic test_frame_div();
        int base;
        base = mx[3];
        repeat (9) run_frame(3, 1);
        n_checks++;
        if (ox[3] !== 10'(base + 3))
            $display("FAIL div3_9f: got x=%0d want %0d", ox[3], base + 3);
        else n_pass++;
    endtask

    task automatic test_clr_in_update();
        en = 1'b1;
        x_px = 10'd639;
        y_px = 10'd479;
        @(posedge clk); #1;
        clr = 1'b0;
        @(posedge clk); #1;
        model_reset();
        for (int i = 0; i < N; i++) begin
            n_checks++;
            if ({ox[i], oy[i], odx[i], ody[i], ob[i]} !==
                {10'(P_XI[i]), 10'(P_YI[i]), 1'b1, 1'b1, 1'b0})
                $display("FAIL clr_in_update u%0d: got x=%0d y=%0d dx=%0b dy=%0b b=%0b want x=%0d y=%0d dx=1 dy=1 b=0",
                         i, ox[i], oy[i], odx[i], ody[i], ob[i], P_XI[i], P_YI[i]);
            else n_pass++;
        end
        set_off();
        @(posedge clk); #1;
        clr = 1'b1;
        @(posedge clk); #1;
        for (int i = 0; i < N; i++) begin
            n_checks++;
            if ({ox[i], oy[i], ob[i]} !== {10'(P_XI[i]), 10'(P_YI[i]), 1'b0})
                $display("FAIL after_clr u%0d: got x=%0d y=%0d b=%0b want x=%0d y=%0d b=0",
                         i, ox[i], oy[i], ob[i], P_XI[i], P_YI[i]);
            else n_pass++;
        end
    endtask

    task automatic test_back_to_back();
        en = 1'b1;
        repeat (6) run_frame(3, 1);
    endtask

    task automatic test_random();
        repeat (40) begin
            en = ($urandom_range(0, 3) != 0);
            run_frame($urandom_range(3, 8), $urandom_range(1, 4));
        end
    endtask

    initial begin
        set_off();
        test_reset();
        test_idle();
        test_three_frames();
        test_hold();
        test_frame_div();
        test_clr_in_update();
        test_back_to_back();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
